// File: rtl/frame_mem_arbiter_pkg.sv
// Shared constants and types for the frame memory arbiter.
package frame_mem_arbiter_pkg;

  localparam int N_REQ = 3;
  localparam int TAG_W = 2;

  localparam logic [TAG_W-1:0] REQ_DISPLAY = 2'd0;
  localparam logic [TAG_W-1:0] REQ_CAMERA  = 2'd1;
  localparam logic [TAG_W-1:0] REQ_PROC    = 2'd2;

  // One slot of the read-return tracker: is a read here, and whose is it.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] id;
  } rd_tag_t;

  // Requester index to one-hot requester mask.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic [TAG_W-1:0] id);
    logic [N_REQ-1:0] mask;
    case (id)
      REQ_DISPLAY: mask = 3'b001;
      REQ_CAMERA:  mask = 3'b010;
      REQ_PROC:    mask = 3'b100;
      default:     mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/frame_mem_arbiter_rd_tag_pipe.sv
// Read-return tag pipeline: one slot per cycle between grant and read data.
// A tag pushed in the grant cycle emerges RD_LAT+1 cycles later, which is when
// the memory presents the data for that read.
module rd_tag_pipe
  import frame_mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [TAG_W-1:0] i_id,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_id
);

  rd_tag_t r_stage [RD_LAT+1];

  // Shift tags one stage per cycle; reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= RD_LAT; k++) begin
        r_stage[k] <= '0;
      end
    end else begin
      r_stage[0].valid <= i_push;
      r_stage[0].id    <= i_id;
      for (int k = 1; k <= RD_LAT; k++) begin
        r_stage[k] <= r_stage[k-1];
      end
    end
  end

  assign o_valid = r_stage[RD_LAT].valid;
  assign o_id    = r_stage[RD_LAT].id;

endmodule

// File: rtl/frame_mem_arbiter.sv
// Three-way frame memory arbiter: display has fixed top priority, camera and
// processing share the remaining slots round-robin. Commands are registered
// onto the memory port; read data is routed back using a tag pipeline.
module frame_mem_arbiter
  import frame_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 36,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req_en,
  input  logic [2:0]        req,
  input  logic [2:0]        req_we,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic [DATA_W-1:0] req_wdata2,
  output logic [2:0]        grant,
  output logic [2:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [2:0]        w_elig;
  logic [2:0]        w_grant;
  logic [TAG_W-1:0]  w_win_idx;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_we;
  logic              w_tag_valid;
  logic [TAG_W-1:0]  w_tag_id;

  // 1 when processing was the most recent camera/processing winner,
  // so camera is next in line on a tie.
  logic              r_last2;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;

  // No grants are offered while reset is held.
  assign w_elig = req & req_en & {3{~reset}};

  // Priority pick: display first, then the camera/processing tie-break.
  always_comb begin
    w_grant = 3'b000;
    if (w_elig[REQ_DISPLAY]) begin
      w_grant = 3'b001;
    end else if (w_elig[REQ_CAMERA] && w_elig[REQ_PROC]) begin
      w_grant = r_last2 ? 3'b010 : 3'b100;
    end else if (w_elig[REQ_CAMERA]) begin
      w_grant = 3'b010;
    end else if (w_elig[REQ_PROC]) begin
      w_grant = 3'b100;
    end
  end

  assign grant = w_grant;

  // Select the winner's command fields.
  always_comb begin
    w_win_idx   = REQ_DISPLAY;
    w_win_addr  = req_addr0;
    w_win_wdata = req_wdata0;
    if (w_grant[REQ_CAMERA]) begin
      w_win_idx   = REQ_CAMERA;
      w_win_addr  = req_addr1;
      w_win_wdata = req_wdata1;
    end else if (w_grant[REQ_PROC]) begin
      w_win_idx   = REQ_PROC;
      w_win_addr  = req_addr2;
      w_win_wdata = req_wdata2;
    end
    w_win_we = req_we[w_win_idx];
  end

  // Register the granted command onto the memory port and advance the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_last2     <= 1'b1;
    end else begin
      if (|w_grant) begin
        r_mem_addr  <= w_win_addr;
        r_mem_we    <= w_win_we;
        r_mem_wdata <= w_win_wdata;
      end else begin
        r_mem_we    <= 1'b0;
      end
      if (w_grant[REQ_CAMERA]) begin
        r_last2 <= 1'b0;
      end else if (w_grant[REQ_PROC]) begin
        r_last2 <= 1'b1;
      end
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

  rd_tag_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .i_push  ((|w_grant) & ~w_win_we),
    .i_id    (w_win_idx),
    .o_valid (w_tag_valid),
    .o_id    (w_tag_id)
  );

  // Steer memory read data to the requester that issued the read.
  always_comb begin
    rvalid = 3'b000;
    rdata  = '0;
    if (w_tag_valid && !reset) begin
      rvalid = id_to_onehot(w_tag_id);
      rdata  = mem_rdata;
    end
  end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Self-checking bench for frame_mem_arbiter: directed scenarios plus a short
// random phase, with read returns checked against a scoreboard queue.
module tb_frame_mem_arbiter;

  localparam int AW = 19;
  localparam int DW = 36;
  localparam int RL = 2;

  logic          clk;
  logic          reset;
  logic [2:0]    req_en;
  logic [2:0]    req;
  logic [2:0]    req_we;
  logic [AW-1:0] a  [3];
  logic [DW-1:0] wd [3];
  logic [2:0]    grant;
  logic [2:0]    rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  frame_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_en     (req_en),
    .req        (req),
    .req_we     (req_we),
    .req_addr0  (a[0]),
    .req_addr1  (a[1]),
    .req_addr2  (a[2]),
    .req_wdata0 (wd[0]),
    .req_wdata1 (wd[1]),
    .req_wdata2 (wd[2]),
    .grant      (grant),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Memory model: data is a fixed function of the address, RL cycles after
  // the registered command.
  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] ad);
    return {ad[16:0] ^ 17'h1A5A5, ad};
  endfunction

  logic [AW-1:0] d1, d2;
  always @(posedge clk) begin
    d1 <= mem_addr;
    d2 <= d1;
  end
  assign mem_rdata = mdata(d2);

  typedef struct {
    int            cyc;
    logic [2:0]    id;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected memory-port state and arbitration history.
  logic [AW-1:0] e_addr;
  logic          e_we;
  logic [DW-1:0] e_wdata;
  logic          m_last2;

  // One cycle: check grant and last cycle's command, then record expectations.
  task automatic tick(input logic [2:0] g);
    int w;
    @(negedge clk);
    check("grant", 64'(grant), 64'(g));
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_wdata", 64'(mem_wdata), 64'(e_wdata));
    if (g != 3'b000) begin
      w = g[0] ? 0 : (g[1] ? 1 : 2);
      e_we    = req_we[w];
      e_addr  = a[w];
      e_wdata = wd[w];
      if (!e_we) sb.push_back('{cyc + 1 + RL, g, mdata(a[w])});
      if (w == 1) m_last2 = 1'b0;
      if (w == 2) m_last2 = 1'b1;
    end else begin
      e_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input int n);
    reset = 1'b1;
    req   = 3'b000;
    repeat (n) begin
      @(negedge clk);
      check("grant_rst", 64'(grant), 64'd0);
      check("rvalid_rst", 64'(rvalid), 64'd0);
      check("rdata_rst", 64'(rdata), 64'd0);
    end
    sb.delete();
    e_addr  = '0;
    e_we    = 1'b0;
    e_wdata = '0;
    m_last2 = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [2:0] arb(input logic [2:0] e, input logic last2);
    if (e[0]) return 3'b001;
    if (e[1] && e[2]) return last2 ? 3'b010 : 3'b100;
    if (e[1]) return 3'b010;
    if (e[2]) return 3'b100;
    return 3'b000;
  endfunction

  // Read-return monitor: every cycle rvalid must match the scoreboard head.
  always @(negedge clk) begin
    logic [2:0] erv;
    erv = 3'b000;
    if (sb.size() > 0 && sb[0].cyc <= cyc) erv = sb[0].id;
    check("rvalid", 64'(rvalid), 64'(erv));
    if (erv != 3'b000) begin
      check("rdata", 64'(rdata), 64'(sb[0].data));
      $display("rd return id=%b data=%h cycle=%0d", rvalid, rdata, cyc);
      void'(sb.pop_front());
    end
  end

  initial begin
    logic [2:0] pend;
    logic [2:0] g;
    int         w;

    reset  = 1'b1;
    req_en = 3'b111;
    req    = 3'b000;
    req_we = 3'b000;
    for (int i = 0; i < 3; i++) begin
      a[i]  = '0;
      wd[i] = '0;
    end
    rst_pulse(2);

    // Camera vs processing alternate, camera first after reset.
    a[1] = 19'h00101;
    a[2] = 19'h00202;
    req  = 3'b110;
    tick(3'b010); tick(3'b100); tick(3'b010); tick(3'b100);
    req = 3'b000;
    tick(3'b000);

    // Display dominates; pointer untouched by display grants.
    a[0] = 19'h00300;
    req  = 3'b111;
    tick(3'b001); tick(3'b001); tick(3'b001);
    req = 3'b110;
    tick(3'b010);
    req = 3'b100;
    tick(3'b100);
    req = 3'b000;
    tick(3'b000);

    // Single display read and its return.
    a[0] = 19'h00010;
    req  = 3'b001;
    tick(3'b001);
    req = 3'b000;
    repeat (4) tick(3'b000);

    // Camera write followed by processing read.
    req_we[1] = 1'b1;
    a[1]      = 19'h12345;
    wd[1]     = 36'hABC;
    req       = 3'b010;
    tick(3'b010);
    req_we[2] = 1'b0;
    a[2]      = 19'h00777;
    req       = 3'b100;
    tick(3'b100);
    req = 3'b000;
    repeat (4) tick(3'b000);

    // Disabling a requester blocks new grants but its read still returns.
    req_we[1] = 1'b0;
    a[1]      = 19'h00555;
    req       = 3'b010;
    tick(3'b010);
    req_en = 3'b101;
    tick(3'b000); tick(3'b000);
    req    = 3'b000;
    req_en = 3'b111;
    tick(3'b000); tick(3'b000);

    // Disabled processing write never reaches memory.
    req_en    = 3'b011;
    req_we[2] = 1'b1;
    req       = 3'b100;
    tick(3'b000); tick(3'b000);
    req       = 3'b000;
    req_en    = 3'b111;
    req_we[2] = 1'b0;
    tick(3'b000);

    // Reset with two reads in flight; last pre-reset winner is camera.
    a[2] = 19'h00BBB;
    req  = 3'b100;
    tick(3'b100);
    a[1] = 19'h00AAA;
    req  = 3'b010;
    tick(3'b010);
    rst_pulse(1);
    repeat (5) tick(3'b000);
    req = 3'b110;
    tick(3'b010);
    req = 3'b000;
    tick(3'b000);

    // Random traffic; requests are held until granted.
    pend = 3'b000;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!pend[i] && $urandom_range(1, 0) == 1) begin
          pend[i]   = 1'b1;
          req_we[i] = 1'($urandom_range(1, 0));
          a[i]      = AW'($urandom);
          wd[i]     = {4'($urandom), 32'($urandom)};
        end
      end
      req = pend;
      g   = arb(pend, m_last2);
      tick(g);
      if (g != 3'b000) begin
        w = g[0] ? 0 : (g[1] ? 1 : 2);
        pend[w] = 1'b0;
      end
    end
    req = 3'b000;
    repeat (6) tick(3'b000);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
